dc_pen_ctrl: RTL and testbench

//  Parametrised pen-lift DC motor controller for the SCARA plotter.
//  - Drives the H-bridge (pwm/dir/brake) to move the pen to the set_pen position.
//  - Adds soft-start duty ramp, limit-switch debounce, travel timeout, driver-fault latch and timed braking.
//  - Sits between the command/register layer and the motor driver pins.

---
 rtl/dc_pen_if.sv | 35 +++
 rtl/dc_pen_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_dc_pen_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dc_pen_if.sv
// ----------------------------------------------------------------------------
// dc_pen_if
// Pin bundle between the pen-lift motor controller and its surroundings.
//   master : drives the command and raw inputs and observes the status and
//            H-bridge outputs (command/register layer, or a test bench).
//   slave  : the controller itself.
// Signals
//   enable, duty[PWM_W], set_pen, limit_switch, fault_n   master -> slave
//   pen_status, busy, fault, pwm, dir, brake               slave  -> master
// ----------------------------------------------------------------------------
interface dc_pen_if #(
    parameter int PWM_W = 8
);
    logic             enable;
    logic [PWM_W-1:0] duty;
    logic             set_pen;
    logic             limit_switch;
    logic             fault_n;
    logic             pen_status;
    logic             busy;
    logic             fault;
    logic             pwm;
    logic             dir;
    logic             brake;

    modport master (
        output enable, duty, set_pen, limit_switch, fault_n,
        input  pen_status, busy, fault, pwm, dir, brake
    );

    modport slave (
        input  enable, duty, set_pen, limit_switch, fault_n,
        output pen_status, busy, fault, pwm, dir, brake
    );
endinterface

// File: rtl/dc_pen_ctrl.sv
// ----------------------------------------------------------------------------
// dc_pen_ctrl
// Pen-lift DC motor controller for the SCARA plotter. Moves the pen to the
// commanded position through an H-bridge, with a soft-start duty ramp, a
// debounced limit switch, a travel timeout, a latched driver-fault state and
// a timed dynamic-brake phase after every completed move.
// Ports
//   clk_50   in   system clock, 50 MHz
//   reset_n  in   synchronous active-low reset
//   bus      slave modport of dc_pen_if:
//            enable, duty, set_pen, limit_switch (raw), fault_n (raw)  in
//            pen_status, busy, fault, pwm, dir, brake (active low)     out
// ----------------------------------------------------------------------------
module dc_pen_ctrl #(
    parameter int PWM_W     = 8,
    parameter int PRESCALE  = 1,
    parameter int DEBOUNCE  = 50000,
    parameter int RAMP_STEP = 8,
    parameter int TIMEOUT   = 25000000,
    parameter int BRAKE_CYC = 50000
) (
    input  logic     clk_50,
    input  logic     reset_n,
    dc_pen_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_STOP,
        S_FAULT
    } state_t;

    localparam int PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    // One timer serves both MOVE (timeout) and STOP (brake hold).
    localparam int TMR_MAX = (TIMEOUT > BRAKE_CYC) ? TIMEOUT : BRAKE_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    // ------------------------------------------------------------------
    // Input synchronisers. Idle levels (switch open = pen up, no fault)
    // are used as reset values so no spurious event follows reset.
    // ------------------------------------------------------------------
    logic ls_s1, ls_s2;
    logic fn_s1, fn_s2;

    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            ls_s1 <= 1'b1;
            ls_s2 <= 1'b1;
            fn_s1 <= 1'b1;
            fn_s2 <= 1'b1;
        end else begin
            ls_s1 <= bus.limit_switch;
            ls_s2 <= ls_s1;
            fn_s1 <= bus.fault_n;
            fn_s2 <= fn_s1;
        end
    end

    // ------------------------------------------------------------------
    // Limit-switch debounce: ls_db follows the synchronised switch only
    // after DEBOUNCE consecutive cycles of disagreement.
    // ------------------------------------------------------------------
    logic            ls_db;
    logic [DB_W-1:0] db_cnt;
    logic            pen_status_i;

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            ls_db  <= 1'b1;
            db_cnt <= '0;
        end else if (ls_s2 == ls_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
            ls_db  <= ls_s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign pen_status_i = ~ls_db;

    // ------------------------------------------------------------------
    // Free-running PWM timebase, active in every state.
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_cnt;
    logic [PWM_W-1:0] pwm_cnt;
    logic             tick;
    logic             wrap;

    assign tick = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign wrap = tick && (pwm_cnt == '1);

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Soft-start ramp. The sum is one bit wider so a large step cannot
    // wrap past the target; the min() also pulls cur_duty down when the
    // target drops mid-move.
    // ------------------------------------------------------------------
    logic [PWM_W-1:0] cur_duty;
    logic [PWM_W:0]   ramp_sum;
    logic [PWM_W-1:0] ramp_next;

    assign ramp_sum  = {1'b0, cur_duty} + (PWM_W + 1)'(RAMP_STEP);
    assign ramp_next = (ramp_sum > {1'b0, bus.duty}) ? bus.duty : ramp_sum[PWM_W-1:0];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer;
    logic             dir_q;
    logic             pwm_q;
    logic             brake_q;
    logic             busy_q;
    logic             fault_q;

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.enable && fn_s2 && (bus.set_pen != pen_status_i)) begin
                    state_nxt = S_MOVE;
                end
            end
            S_MOVE: begin
                // Priority: fault, timeout, disable, arrival, reversal.
                if (!fn_s2) begin
                    state_nxt = S_FAULT;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    state_nxt = S_FAULT;
                end else if (!bus.enable) begin
                    state_nxt = S_IDLE;
                end else if (pen_status_i == dir_q) begin
                    state_nxt = S_STOP;
                end else if (bus.set_pen != dir_q) begin
                    // A reversal brakes first; IDLE then relaunches.
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (!fn_s2) begin
                    state_nxt = S_FAULT;
                end else if (timer == TMR_W'(BRAKE_CYC - 1)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_FAULT: begin
                if (!bus.enable && fn_s2) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            timer    <= '0;
            cur_duty <= '0;
            dir_q    <= 1'b0;
            pwm_q    <= 1'b0;
            brake_q  <= 1'b1;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy_q  <= (state_nxt != S_IDLE);
            fault_q <= (state_nxt == S_FAULT);
            brake_q <= (state_nxt != S_STOP);
            pwm_q   <= (state == S_MOVE) && (state_nxt == S_MOVE) && (pwm_cnt < cur_duty);

            if (state_nxt != state) begin
                timer <= '0;
            end else if ((state == S_MOVE) || (state == S_STOP)) begin
                timer <= timer + 1'b1;
            end

            if ((state == S_IDLE) && (state_nxt == S_MOVE)) begin
                dir_q    <= bus.set_pen;
                cur_duty <= '0;
            end else if ((state == S_MOVE) && (state_nxt == S_MOVE) && wrap) begin
                cur_duty <= ramp_next;
            end
        end
    end

    assign bus.pen_status = pen_status_i;
    assign bus.busy       = busy_q;
    assign bus.fault      = fault_q;
    assign bus.pwm        = pwm_q;
    assign bus.dir        = dir_q;
    assign bus.brake      = brake_q;

endmodule

// File: tb/tb_dc_pen_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dc_pen_ctrl
// Directed bench for dc_pen_ctrl with PWM_W=4 PRESCALE=1 DEBOUNCE=4
// RAMP_STEP=4 TIMEOUT=200 BRAKE_CYC=8. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Expected values are hand-derived:
//   limit change -> pen_status: 2 sync + 4 debounce cycles = 6th falling edge
//   arrival -> brake low the next edge, held 8 cycles
//   fault_n pulse -> fault visible at the 3rd falling edge
//   timeout -> fault first seen 200 cycles after busy is first seen
// ----------------------------------------------------------------------------
module tb_dc_pen_ctrl;

    localparam int PWM_W     = 4;
    localparam int PRESCALE  = 1;
    localparam int DEBOUNCE  = 4;
    localparam int RAMP_STEP = 4;
    localparam int TIMEOUT   = 200;
    localparam int BRAKE_CYC = 8;

    logic clk_50 = 1'b0;
    logic reset_n;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_50 = ~clk_50;

    dc_pen_if #(.PWM_W(PWM_W)) bus ();

    dc_pen_ctrl #(
        .PWM_W     (PWM_W),
        .PRESCALE  (PRESCALE),
        .DEBOUNCE  (DEBOUNCE),
        .RAMP_STEP (RAMP_STEP),
        .TIMEOUT   (TIMEOUT),
        .BRAKE_CYC (BRAKE_CYC)
    ) dut (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Waits up to max_cyc falling edges for busy; returns edges waited.
    task automatic wait_busy(input logic level, input int max_cyc, output int n);
        n = 0;
        while (bus.busy !== level && n < max_cyc) begin
            @(negedge clk_50);
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n          = 1'b0;
        bus.enable       = 1'b1;
        bus.duty         = 4'd15;
        bus.set_pen      = 1'b0;
        bus.limit_switch = 1'b1;
        bus.fault_n      = 1'b1;
        repeat (3) @(negedge clk_50);
        reset_n = 1'b1;
        repeat (10) @(negedge clk_50);
        tests_run++;
        if (bus.pwm !== 1'b0) begin
            tests_failed++; $display("FAIL reset_pwm: got %b want 0", bus.pwm);
        end
        tests_run++;
        if (bus.brake !== 1'b1) begin
            tests_failed++; $display("FAIL reset_brake: got %b want 1", bus.brake);
        end
        tests_run++;
        if (bus.pen_status !== 1'b0) begin
            tests_failed++; $display("FAIL reset_pen_status: got %b want 0", bus.pen_status);
        end
        tests_run++;
        if (bus.busy !== 1'b0 || bus.fault !== 1'b0 || bus.dir !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy_fault_dir: got %b%b%b want 000", bus.busy, bus.fault, bus.dir);
        end
    endtask

    task automatic test_ramp();
        int n;
        int width;
        int exp_w[5] = '{4, 8, 12, 15, 15};
        bus.set_pen = 1'b1;
        wait_busy(1'b1, 5, n);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.dir !== 1'b1) begin
            tests_failed++; $display("FAIL ramp_start: busy=%b dir=%b want 1 1", bus.busy, bus.dir);
        end
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 40 && bus.pwm !== 1'b1; k++) @(negedge clk_50);
            width = 0;
            while (bus.pwm === 1'b1 && width < 40) begin
                width++;
                @(negedge clk_50);
            end
            tests_run++;
            if (width != exp_w[i]) begin
                tests_failed++; $display("FAIL ramp_pulse%0d: got %0d want %0d", i, width, exp_w[i]);
            end
        end
    endtask

    task automatic test_arrival();
        int n;
        int brake_cnt;
        bus.limit_switch = 1'b0;
        n = 0;
        while (bus.pen_status !== 1'b1 && n < 12) begin
            @(negedge clk_50);
            n++;
        end
        tests_run++;
        if (n != 6) begin
            tests_failed++; $display("FAIL arrival_debounce_latency: got %0d want 6", n);
        end
        n = 0;
        while (bus.brake !== 1'b0 && n < 6) begin
            @(negedge clk_50);
            n++;
        end
        tests_run++;
        if (bus.brake !== 1'b0 || bus.busy !== 1'b1 || bus.pwm !== 1'b0) begin
            tests_failed++;
            $display("FAIL arrival_stop: brake=%b busy=%b pwm=%b want 0 1 0", bus.brake, bus.busy, bus.pwm);
        end
        brake_cnt = 0;
        while (bus.brake === 1'b0 && brake_cnt < 30) begin
            brake_cnt++;
            @(negedge clk_50);
        end
        tests_run++;
        if (brake_cnt != BRAKE_CYC) begin
            tests_failed++; $display("FAIL arrival_brake_len: got %0d want %0d", brake_cnt, BRAKE_CYC);
        end
        tests_run++;
        if (bus.busy !== 1'b0 || bus.brake !== 1'b1) begin
            tests_failed++; $display("FAIL arrival_idle: busy=%b brake=%b want 0 1", bus.busy, bus.brake);
        end
    endtask

    task automatic test_bounce();
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus.limit_switch = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (2) begin
                @(negedge clk_50);
                if (bus.pen_status !== 1'b1 || bus.busy !== 1'b0) bad++;
            end
        end
        repeat (8) begin
            @(negedge clk_50);
            if (bus.pen_status !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL bounce_stable: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_timeout();
        int n;
        int cyc;
        bus.set_pen = 1'b0;
        wait_busy(1'b1, 5, n);
        cyc = 0;
        while (bus.fault !== 1'b1 && cyc < 400) begin
            @(negedge clk_50);
            cyc++;
        end
        tests_run++;
        if (cyc != TIMEOUT) begin
            tests_failed++; $display("FAIL timeout_cycle: got %0d want %0d", cyc, TIMEOUT);
        end
        repeat (5) @(negedge clk_50);
        tests_run++;
        if (bus.fault !== 1'b1 || bus.pwm !== 1'b0 || bus.brake !== 1'b1 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_latched: fault=%b pwm=%b brake=%b busy=%b want 1 0 1 1",
                     bus.fault, bus.pwm, bus.brake, bus.busy);
        end
        bus.enable = 1'b0;
        repeat (3) @(negedge clk_50);
        tests_run++;
        if (bus.fault !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL timeout_clear: fault=%b busy=%b want 0 0", bus.fault, bus.busy);
        end
        bus.enable = 1'b1;
        repeat (3) @(negedge clk_50);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.dir !== 1'b0 || bus.fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_restart: busy=%b dir=%b fault=%b want 1 0 0", bus.busy, bus.dir, bus.fault);
        end
    endtask

    task automatic test_abort();
        int brake_low = 0;
        repeat (10) @(negedge clk_50);
        bus.enable = 1'b0;
        repeat (6) begin
            @(negedge clk_50);
            if (bus.brake !== 1'b1) brake_low++;
        end
        tests_run++;
        if (brake_low != 0 || bus.busy !== 1'b0 || bus.pwm !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_brake: brake_low=%0d busy=%b pwm=%b want 0 0 0", brake_low, bus.busy, bus.pwm);
        end
        bus.enable = 1'b1;
        repeat (3) @(negedge clk_50);
    endtask

    task automatic test_fault();
        int n;
        int brake_low = 0;
        bus.fault_n = 1'b0;
        @(negedge clk_50);
        bus.fault_n = 1'b1;
        n = 1;
        while (bus.fault !== 1'b1 && n < 10) begin
            @(negedge clk_50);
            n++;
        end
        tests_run++;
        if (n > 3 || bus.fault !== 1'b1 || bus.pwm !== 1'b0) begin
            tests_failed++; $display("FAIL fault_pulse: got %0d cycles fault=%b want <=3 1", n, bus.fault);
        end
        bus.enable = 1'b0;
        repeat (3) @(negedge clk_50);
        bus.enable = 1'b1;
        repeat (3) @(negedge clk_50);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.fault !== 1'b0) begin
            tests_failed++; $display("FAIL fault_relaunch: busy=%b fault=%b want 1 0", bus.busy, bus.fault);
        end
        // Arrival (pen_status -> 0 == dir) and synchronised fault land on the same cycle.
        bus.limit_switch = 1'b1;
        repeat (4) @(negedge clk_50);
        bus.fault_n = 1'b0;
        repeat (12) begin
            @(negedge clk_50);
            if (bus.brake !== 1'b1) brake_low++;
        end
        tests_run++;
        if (bus.pen_status !== 1'b0) begin
            tests_failed++; $display("FAIL race_arrived: pen_status=%b want 0", bus.pen_status);
        end
        tests_run++;
        if (brake_low != 0 || bus.fault !== 1'b1) begin
            tests_failed++; $display("FAIL race_fault_wins: brake_low=%0d fault=%b want 0 1", brake_low, bus.fault);
        end
        bus.fault_n = 1'b1;
        bus.enable  = 1'b0;
        repeat (4) @(negedge clk_50);
        bus.enable  = 1'b1;
        repeat (4) @(negedge clk_50);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.fault !== 1'b0) begin
            tests_failed++; $display("FAIL race_recover: busy=%b fault=%b want 0 0", bus.busy, bus.fault);
        end
    endtask

    task automatic test_reset_mid_move();
        bus.set_pen = 1'b1;
        for (int k = 0; k < 60 && bus.pwm !== 1'b1; k++) @(negedge clk_50);
        reset_n = 1'b0;
        @(negedge clk_50);
        tests_run++;
        if (bus.pwm !== 1'b0 || bus.brake !== 1'b1 || bus.busy !== 1'b0 || bus.dir !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_move: pwm=%b brake=%b busy=%b dir=%b want 0 1 0 0",
                     bus.pwm, bus.brake, bus.busy, bus.dir);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk_50);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_50);
        test_reset();
        test_ramp();
        test_arrival();
        test_bounce();
        test_timeout();
        test_abort();
        test_fault();
        test_reset_mid_move();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
